// File: rtl/cache_core_if.sv
// cache_core_if: CPU request/response and DRAM-side request/refill signals of cache_core.
// Latency: none (wires only).
// Backpressure: req_rdy throttles the CPU side; mem_req_ready throttles the memory side.
interface cache_core_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = DATA_W * LINE_WORDS;

  logic              readtrigger;
  logic              writetrigger;
  logic              flushtrigger;
  logic [ADDR_W-1:0] input_addr;
  logic [DATA_W-1:0] input_data;
  logic              req_rdy;
  logic [DATA_W-1:0] output_data;
  logic              rsp_valid;
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_rdata;

  // Cache side
  modport slave (
    input  readtrigger, writetrigger, flushtrigger, input_addr, input_data,
    output req_rdy, output_data, rsp_valid,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  // CPU + memory side
  modport master (
    output readtrigger, writetrigger, flushtrigger, input_addr, input_data,
    input  req_rdy, output_data, rsp_valid,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/cache_core.sv
// cache_core: set-associative (1/2-way, LRU) write-back write-allocate cache with full-line refill and flush.
// Latency: hit -> rsp_valid in the cycle after edge T+2 of acceptance edge T; misses add memory handshake and refill wait.
// Backpressure: req_rdy low while busy; memory requests hold valid/we/addr/wdata stable until mem_req_ready.
module cache_core #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input logic         clk,
  input logic         reset,
  cache_core_if.slave bus
);
  localparam int BO_W    = $clog2(DATA_W / 8);
  localparam int WO_W    = $clog2(LINE_WORDS);
  localparam int WO_WS   = (WO_W > 0) ? WO_W : 1;
  localparam int IDX_W   = $clog2(SETS);
  localparam int IDX_LSB = BO_W + WO_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam int LINE_W  = DATA_W * LINE_WORDS;
  localparam int ENT_W   = $clog2(SETS * WAYS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_RWAIT, S_FLUSH, S_FLUSH_WB, S_DONE
  } state_t;

  state_t            state_q;
  logic              req_rdy_q, rsp_valid_q, wr_q, victim_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [ENT_W-1:0]  fl_cnt_q;
  logic              mreq_vld_q, mreq_we_q;
  logic [ADDR_W-1:0] mreq_addr_q;
  logic [LINE_W-1:0] mreq_wdat_q;

  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic              lru_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] line_q  [WAYS][SETS];

  logic [IDX_W-1:0]  req_idx, fl_set;
  logic [TAG_W-1:0]  req_tag, vic_tag;
  logic [WO_WS-1:0]  req_wofs;
  logic [ADDR_W-1:0] addr_sh, line_addr, vic_addr, fl_addr;
  logic [ENT_W-1:0]  fl_sh;
  logic              fl_way, fl_last, fl_vd;
  logic              hit, hit_way, victim, vic_dirty;
  logic [LINE_W-1:0] hit_line, hit_merged, vic_line, fill_line;
  logic [DATA_W-1:0] hit_word, fill_word;
  logic              unused_bits;

  assign req_idx   = addr_q[TAG_LSB-1:IDX_LSB];
  assign req_tag   = addr_q[ADDR_W-1:TAG_LSB];
  assign addr_sh   = addr_q >> BO_W;
  assign req_wofs  = addr_sh[WO_WS-1:0] & WO_WS'(LINE_WORDS - 1);
  assign line_addr = ADDR_W'({req_tag, req_idx}) << IDX_LSB;

  // Flush walks entries as {set, way}, so way toggles fastest.
  assign fl_sh   = fl_cnt_q >> (WAYS - 1);
  assign fl_set  = fl_sh[IDX_W-1:0];
  assign fl_way  = (WAYS == 2) ? fl_cnt_q[0] : 1'b0;
  assign fl_last = (fl_cnt_q == ENT_W'(SETS * WAYS - 1));
  assign fl_vd   = valid_q[fl_way][fl_set] && dirty_q[fl_way][fl_set];
  assign fl_addr = ADDR_W'({tag_q[fl_way][fl_set], fl_set}) << IDX_LSB;

  assign unused_bits = ^{addr_q, addr_sh, fl_sh};

  // Tag compare across all valid ways of the registered index.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2 && valid_q[0][req_idx])
      victim = valid_q[WAYS-1][req_idx] ? lru_q[req_idx] : 1'b1;
  end

  assign vic_tag   = tag_q[victim][req_idx];
  assign vic_line  = line_q[victim][req_idx];
  assign vic_dirty = valid_q[victim][req_idx] && dirty_q[victim][req_idx];
  assign vic_addr  = ADDR_W'({vic_tag, req_idx}) << IDX_LSB;
  assign hit_line  = line_q[hit_way][req_idx];
  assign hit_word  = hit_line[req_wofs*DATA_W +: DATA_W];
  assign fill_word = fill_line[req_wofs*DATA_W +: DATA_W];

  // Write-word merge into the hit line and into the incoming refill line.
  always_comb begin
    hit_merged = hit_line;
    hit_merged[req_wofs*DATA_W +: DATA_W] = wdata_q;
    fill_line = bus.mem_rsp_rdata;
    if (wr_q) fill_line[req_wofs*DATA_W +: DATA_W] = wdata_q;
  end

  // Line and tag storage: written on a write hit and when a refill is installed.
  always_ff @(posedge clk) begin
    if (state_q == S_LOOKUP && hit && wr_q)
      line_q[hit_way][req_idx] <= hit_merged;
    if (state_q == S_RWAIT && bus.mem_rsp_valid) begin
      line_q[victim_q][req_idx] <= fill_line;
      tag_q[victim_q][req_idx]  <= req_tag;
    end
  end

  // Control FSM with registered outputs plus valid/dirty/LRU state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_rdy_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      victim_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      fl_cnt_q    <= '0;
      mreq_vld_q  <= 1'b0;
      mreq_we_q   <= 1'b0;
      mreq_addr_q <= '0;
      mreq_wdat_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // First IDLE cycle after DONE carries the response; ready follows.
          rsp_valid_q <= 1'b0;
          req_rdy_q   <= 1'b1;
          if (req_rdy_q && (bus.flushtrigger || bus.writetrigger || bus.readtrigger)) begin
            req_rdy_q <= 1'b0;
            addr_q    <= bus.input_addr;
            wdata_q   <= bus.input_data;
            wr_q      <= !bus.flushtrigger && bus.writetrigger;
            fl_cnt_q  <= '0;
            state_q   <= bus.flushtrigger ? S_FLUSH : S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (wr_q) dirty_q[hit_way][req_idx] <= 1'b1;
            else      rdata_q <= hit_word;
            if (WAYS == 2) lru_q[req_idx] <= ~hit_way;
            state_q <= S_DONE;
          end else begin
            victim_q   <= victim;
            mreq_vld_q <= 1'b1;
            if (vic_dirty) begin
              mreq_we_q   <= 1'b1;
              mreq_addr_q <= vic_addr;
              mreq_wdat_q <= vic_line;
              state_q     <= S_WB;
            end else begin
              mreq_we_q   <= 1'b0;
              mreq_addr_q <= line_addr;
              state_q     <= S_REFILL;
            end
          end
        end
        S_WB: begin
          // Write-back accepted: reissue immediately as the refill read.
          if (bus.mem_req_ready) begin
            mreq_we_q   <= 1'b0;
            mreq_addr_q <= line_addr;
            state_q     <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.mem_req_ready) begin
            mreq_vld_q <= 1'b0;
            state_q    <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (bus.mem_rsp_valid) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= wr_q;
            if (WAYS == 2) lru_q[req_idx] <= ~victim_q;
            if (!wr_q) rdata_q <= fill_word;
            state_q <= S_DONE;
          end
        end
        S_FLUSH: begin
          valid_q[fl_way][fl_set] <= 1'b0;
          dirty_q[fl_way][fl_set] <= 1'b0;
          if (fl_vd) begin
            mreq_vld_q  <= 1'b1;
            mreq_we_q   <= 1'b1;
            mreq_addr_q <= fl_addr;
            mreq_wdat_q <= line_q[fl_way][fl_set];
            state_q     <= S_FLUSH_WB;
          end else if (fl_last) begin
            state_q <= S_DONE;
          end else begin
            fl_cnt_q <= fl_cnt_q + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          if (bus.mem_req_ready) begin
            mreq_vld_q <= 1'b0;
            if (fl_last) begin
              state_q <= S_DONE;
            end else begin
              fl_cnt_q <= fl_cnt_q + 1'b1;
              state_q  <= S_FLUSH;
            end
          end
        end
        S_DONE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_rdy       = req_rdy_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.output_data   = rdata_q;
  assign bus.mem_req_valid = mreq_vld_q;
  assign bus.mem_req_we    = mreq_we_q;
  assign bus.mem_req_addr  = mreq_addr_q;
  assign bus.mem_req_wdata = mreq_wdat_q;
endmodule
